pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIDTH, 32, operand and sum width in bits.
- STAGES, 2, pipeline depth; each stage adds one WIDTH/STAGES-bit slice.
REQ-002 Legal parameters SHALL be WIDTH >= 2, 1 <= STAGES <= WIDTH, and WIDTH % STAGES == 0; an illegal set SHALL stop elaboration with an error.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  an operand set is present.
- in_ready  output  1  the block accepts an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; ignored when sub=1.
- sub  input  1  0 selects a+b+c_in; 1 selects a-b.
- out_valid  output  1  a result is present.
- out_ready  input  1  the consumer accepts the result.
- s  output  WIDTH  sum or difference.
- c_out  output  1  carry out of the MSB (for sub, 1 means no borrow).
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  s is all zeros.

Function
REQ-004 sub=1 SHALL compute a + ~b + 1, with c_in forced to 1 and b inverted at the input.
REQ-005 Stage k (0-based) SHALL add slice [(k+1)*W/STAGES-1 : k*W/STAGES] using the carry registered by stage k-1; stage 0 SHALL use the effective c_in.
REQ-006 Stage k SHALL register, per entry, the completed low-order sum slices, the carry out of its slice, and the not-yet-added operand slices (skew buffering).
REQ-007 A transfer SHALL occur on in_valid && in_ready, and the operand set SHALL be captured on that edge.
REQ-008 Latency SHALL be exactly STAGES cycles: the result of an operand set accepted at edge N SHALL appear with out_valid=1 after edge N+STAGES-1, with no stall in between.
REQ-009 Throughput SHALL be one operand set per cycle while out_ready=1.
REQ-010 Each stage SHALL hold a valid bit; a stage SHALL advance when the next stage is empty or also advances.
- Bubbles SHALL collapse; an empty stage never blocks an upstream stage.
REQ-011 The result entry SHALL advance when out_ready=1 or out_valid=0.
REQ-012 in_ready SHALL be 1 when stage 0 is empty or stage 0 advances this cycle; in_ready SHALL NOT depend combinationally on in_valid.
REQ-013 While out_valid=1 && out_ready=0, the outputs s, c_out, ovf and zero SHALL hold stable.
REQ-014 A full pipeline stalled by out_ready=0 SHALL deassert in_ready and lose or duplicate no entry.
REQ-015 For simultaneous accept at the input and drain at the output in the same cycle, both SHALL take effect, with no extra bubble.
REQ-016 The flag outputs SHALL be defined as follows:
- ovf = carry into the MSB XOR carry out of the MSB.
- zero = (s == 0).
- Both SHALL be registered with s.
REQ-017 Outputs SHALL match the full-width arithmetic result (a + b + c_in, or a - b) mod 2^WIDTH, with c_out equal to bit WIDTH of that result.
REQ-018 With STAGES=1 the block SHALL be a single registered adder with the same handshake.

Reset
REQ-019 rst_n=0 SHALL asynchronously clear all stage valid bits, so out_valid=0 immediately.
REQ-020 During reset, in_ready SHALL be 0, and s, c_out, ovf and zero SHALL be 0.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight entries, and no result from before reset SHALL emerge afterwards.
REQ-022 in_ready SHALL rise on the first clock edge after rst_n deasserts; data registers need not be reset beyond the output registers.

Verification (WIDTH=32, STAGES=2 unless stated)
REQ-023 Stimulus a=0xFFFFFFFF, b=0x00000001, c_in=0, sub=0, out_ready=1 -> two cycles later: s=0x00000000, c_out=1, zero=1, ovf=0, out_valid=1 for one cycle.
REQ-024 Stimulus a=0x7FFFFFFF, b=0x00000001, sub=0 -> s=0x80000000, ovf=1, c_out=0; then a=5, b=7, sub=1 -> s=0xFFFFFFFE, c_out=0, ovf=0.
REQ-025 Back-to-back stream of 100 random sets, with out_ready=1 and random sub/c_in -> 100 results in order, one per cycle, each matching the reference arithmetic.
REQ-026 Same stream with out_ready toggled randomly -> no loss, reorder or duplication of results; outputs stable while stalled; in_ready=0 only when full and stalled.
REQ-027 Reset pulsed while 2 entries are in flight -> out_valid=0 immediately; no stale result after release; the first new input yields the correct result STAGES cycles later.
REQ-028 Rerun the random stream for (WIDTH, STAGES) in {(8,1), (16,4), (64,8)} -> results correct and latency equal to STAGES.

Source files
------------

// File: rtl/pipelined_adder.sv
// Carry-skewed pipelined adder/subtractor: each stage adds one WIDTH/STAGES-bit slice,
// with a valid/ready handshake whose last stage doubles as the registered output.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = (STAGES > 0) ? (WIDTH / STAGES) : 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % SW) != 0 || (SW * STAGES) != WIDTH)
  begin : g_bad_params
    $error("pipelined_adder: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
  end

  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic              rdy_q;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] vin;

  logic [SW-1:0]     op_a  [STAGES];
  logic [SW-1:0]     op_b  [STAGES];
  logic              cin_c [STAGES];
  logic [WIDTH-1:0]  low_c [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic              cout_d [STAGES];

  logic [WIDTH-1:0]  s_q;
  logic              c_q;
  logic              ovf_q;
  logic              zero_q;
  logic              ovf_d;
  logic              zero_d;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | c_in;

  assign op_a[0]  = a[SW-1:0];
  assign op_b[0]  = b_eff[SW-1:0];
  assign cin_c[0] = cin_eff;
  assign low_c[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW:0] t;

    assign t         = {1'b0, op_a[k]} + {1'b0, op_b[k]} + {{SW{1'b0}}, cin_c[k]};
    assign res_d[k]  = low_c[k] | (WIDTH'(t[SW-1:0]) << (k * SW));
    assign cout_d[k] = t[SW];

    // Flattened form of "stage k may load if the next stage is empty or also loads":
    // a register loads when the consumer drains or any register at or after it is empty.
    assign ld[k] = out_ready | ~(&valid_q[STAGES-1:k]);

    if (k == 0) begin : g_vin_first
      assign vin[k] = in_valid & in_ready;
    end else begin : g_vin_next
      assign vin[k] = valid_q[k-1];
    end
  end

  // Carry into the MSB is recovered as a ^ b ^ s at that bit.
  assign ovf_d  = op_a[STAGES-1][SW-1] ^ op_b[STAGES-1][SW-1]
                ^ res_d[STAGES-1][WIDTH-1] ^ cout_d[STAGES-1];
  assign zero_d = (res_d[STAGES-1] == '0);

  assign in_ready  = rdy_q & ld[0];
  assign out_valid = valid_q[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q   <= 1'b0;
      valid_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (ld[k]) valid_q[k] <= vin[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      c_q    <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (ld[STAGES-1] && vin[STAGES-1]) begin
      s_q    <= res_d[STAGES-1];
      c_q    <= cout_d[STAGES-1];
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  if (STAGES > 1) begin : g_skew
    // Operands are kept pre-shifted so the next stage always adds the low slice.
    logic [WIDTH-1:0] a_q   [STAGES-1];
    logic [WIDTH-1:0] b_q   [STAGES-1];
    logic [WIDTH-1:0] sum_q [STAGES-1];
    logic             cy_q  [STAGES-1];
    logic [WIDTH-1:0] a_d   [STAGES-1];
    logic [WIDTH-1:0] b_d   [STAGES-1];

    assign a_d[0] = a >> SW;
    assign b_d[0] = b_eff >> SW;

    for (genvar k = 1; k < STAGES - 1; k++) begin : g_shift
      assign a_d[k] = a_q[k-1] >> SW;
      assign b_d[k] = b_q[k-1] >> SW;
    end

    always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < STAGES - 1; k++) begin
        if (ld[k] && vin[k]) begin
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          sum_q[k] <= res_d[k];
          cy_q[k]  <= cout_d[k];
        end
      end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_feed
      assign op_a[k]  = a_q[k-1][SW-1:0];
      assign op_b[k]  = b_q[k-1][SW-1:0];
      assign cin_c[k] = cy_q[k-1];
      assign low_c[k] = sum_q[k-1];
    end
  end

  assign s     = s_q;
  assign c_out = c_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: four configurations share one stimulus stream,
// each with its own expected-result queue.
module tb_pipelined_adder;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    logic        z;
    bit          lat;
    int          cyc;
  } exp_t;

  localparam int W_OF  [4] = '{32, 8, 16, 64};
  localparam int ST_OF [4] = '{2, 1, 4, 8};

  logic        clk = 1'b0;
  logic        rst_n, in_valid, c_in, sub, out_ready;
  logic [63:0] a, b;

  logic [63:0] s_w  [4];
  logic        ir_w [4];
  logic        ov_w [4];
  logic        co_w [4];
  logic        of_w [4];
  logic        z_w  [4];
  logic [31:0] s32;
  logic [7:0]  s8;
  logic [15:0] s16;
  logic [63:0] s64;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .STAGES(2)) u_w32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_w[0]),
    .a(a[31:0]), .b(b[31:0]), .c_in(c_in), .sub(sub),
    .out_valid(ov_w[0]), .out_ready(out_ready), .s(s32),
    .c_out(co_w[0]), .ovf(of_w[0]), .zero(z_w[0]));

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_w[1]),
    .a(a[7:0]), .b(b[7:0]), .c_in(c_in), .sub(sub),
    .out_valid(ov_w[1]), .out_ready(out_ready), .s(s8),
    .c_out(co_w[1]), .ovf(of_w[1]), .zero(z_w[1]));

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_w[2]),
    .a(a[15:0]), .b(b[15:0]), .c_in(c_in), .sub(sub),
    .out_valid(ov_w[2]), .out_ready(out_ready), .s(s16),
    .c_out(co_w[2]), .ovf(of_w[2]), .zero(z_w[2]));

  pipelined_adder #(.WIDTH(64), .STAGES(8)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_w[3]),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(ov_w[3]), .out_ready(out_ready), .s(s64),
    .c_out(co_w[3]), .ovf(of_w[3]), .zero(z_w[3]));

  assign s_w[0] = {32'd0, s32};
  assign s_w[1] = {56'd0, s8};
  assign s_w[2] = {48'd0, s16};
  assign s_w[3] = s64;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          rnd_rdy, chk_rdy, dir_en;
  exp_t        dir_exp;
  exp_t        sb [4][$];
  logic        held_v [4];
  logic [63:0] held_s [4];
  logic [2:0]  held_f [4];

  function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                 input logic ci, input logic sb_);
    exp_t        e;
    logic [63:0] m, aa, bb, ss;
    logic [64:0] t;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = av & m;
    bb   = (sb_ ? ~bv : bv) & m;
    t    = {1'b0, aa} + {1'b0, bb} + {64'd0, (sb_ | ci)};
    ss   = t[63:0] & m;
    e.s  = ss;
    e.c  = t[w];
    e.z  = (ss == 64'd0);
    e.o  = (aa[w-1] == bb[w-1]) && (ss[w-1] != aa[w-1]);
    e.lat = 1'b0;
    e.cyc = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input int unsigned idx,
                     input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[w%0d] got=%0h exp=%0h", tag, W_OF[idx], got, exp);
    end
  endtask

  task automatic tick(output bit acc0);
    exp_t e;
    acc0 = 1'b0;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rst_n) begin
        chk("rst_out_valid", i, 64'(ov_w[i]), 64'd0);
        chk("rst_in_ready", i, 64'(ir_w[i]), 64'd0);
        chk("rst_s", i, s_w[i], 64'd0);
        chk("rst_flags", i, {61'd0, co_w[i], of_w[i], z_w[i]}, 64'd0);
        held_v[i] = 1'b0;
      end else begin
        if (held_v[i]) begin
          chk("stall_s", i, s_w[i], held_s[i]);
          chk("stall_flags", i, {61'd0, co_w[i], of_w[i], z_w[i]}, {61'd0, held_f[i]});
        end
        if (ov_w[i] && out_ready) begin
          chk("unexpected_out", i, 64'(sb[i].size() != 0), 64'd1);
          if (sb[i].size() != 0) begin
            e = sb[i].pop_front();
            chk("s", i, s_w[i], e.s);
            chk("flags", i, {61'd0, co_w[i], of_w[i], z_w[i]}, {61'd0, e.c, e.o, e.z});
            if (e.lat) chk("latency", i, 64'(cyc - e.cyc), 64'(ST_OF[i]));
          end
        end
        held_v[i] = ov_w[i] && !out_ready;
        held_s[i] = s_w[i];
        held_f[i] = {co_w[i], of_w[i], z_w[i]};
        if (in_valid && ir_w[i]) begin
          e     = (dir_en && i == 0) ? dir_exp : model(W_OF[i], a, b, c_in, sub);
          e.lat = !rnd_rdy;
          e.cyc = cyc;
          sb[i].push_back(e);
          if (i == 0) acc0 = 1'b1;
        end
        if (i == 0 && chk_rdy && !ir_w[0])
          chk("in_ready_low_not_stalled", 0, 64'(ov_w[0] && !out_ready), 64'd1);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    bit acc;
    in_valid = 1'b0;
    for (int unsigned k = 0; k < n; k++) tick(acc);
  endtask

  task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic ci,
                      input logic sb_, input int unsigned budget, output int unsigned used);
    bit acc;
    a = av; b = bv; c_in = ci; sub = sb_; in_valid = 1'b1;
    acc  = 1'b0;
    used = 0;
    while (!acc && used < budget) begin
      tick(acc);
      used++;
    end
    chk("accept", 0, 64'(acc), 64'd1);
  endtask

  task automatic dir(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                     input logic sb_, input logic [31:0] es, input logic ec,
                     input logic eo, input logic ez);
    int unsigned used;
    dir_exp.s = {32'd0, es};
    dir_exp.c = ec;
    dir_exp.o = eo;
    dir_exp.z = ez;
    dir_en    = 1'b1;
    send({32'd0, av}, {32'd0, bv}, ci, sb_, 8, used);
    dir_en    = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    int unsigned used;
    int unsigned pend;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    out_ready = 1'b1; rnd_rdy = 1'b0; chk_rdy = 1'b0; dir_en = 1'b0;
    for (int unsigned i = 0; i < 4; i++) held_v[i] = 1'b0;

    idle(3);
    rst_n = 1'b1;
    chk("rdy_before_edge", 0, 64'(ir_w[0]), 64'd0);
    idle(1);
    chk("rdy_after_edge", 0, 64'(ir_w[0]), 64'd1);
    chk_rdy = 1'b1;

    dir(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    idle(4);
    dir(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    dir(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    dir(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    dir(32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    dir(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    dir(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    dir(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    idle(10);

    for (int unsigned n = 0; n < 100; n++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 4, used);
      chk("throughput", 0, 64'(used), 64'd1);
    end
    idle(12);

    rnd_rdy = 1'b1;
    for (int unsigned n = 0; n < 100; n++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 50, used);
    in_valid = 1'b0;
    rnd_rdy  = 1'b0;
    idle(12);

    send(64'd100, 64'd23, 1'b0, 1'b0, 4, used);
    send(64'd9, 64'd40, 1'b0, 1'b1, 4, used);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int unsigned i = 0; i < 4; i++) begin
      chk("rst_async_out_valid", i, 64'(ov_w[i]), 64'd0);
      sb[i].delete();
      held_v[i] = 1'b0;
    end
    chk_rdy = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("rdy_after_rst", 0, 64'(ir_w[0]), 64'd1);
    chk_rdy = 1'b1;
    idle(10);
    dir(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);

    pend = 1;
    for (int unsigned k = 0; k < 50 && pend != 0; k++) begin
      idle(1);
      pend = sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size();
    end
    chk("drain", 0, 64'(pend), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
